spi_writer: RTL and testbench

SPI responder transmit path for the FPGA, working alongside `spi_reader` on the same external SPI bus. It accepts bytes from fabric logic over a valid/ready handshake and shifts them MSB-first onto the FPGA-to-MCU data pin, clocked by the MCU's SCK in SPI mode 0. SCK and CS are oversampled in the single system clock domain. When no byte is queued, the block sends a fill byte and flags an underrun.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 61 ++++++
 rtl/spi_writer.sv | 136 +++++++++++++
 tb/tb_spi_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder reader/writer pair.
// Both blocks use the same synchronizer/edge-detector output struct.
package spi_pkg;

    localparam int                    SPI_DATA_W    = 8;
    localparam logic [SPI_DATA_W-1:0] SPI_FILL_BYTE = 8'hFF;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    typedef struct packed {
        logic cs_n;
        logic cs_fall;
        logic cs_rise;
        logic sck_rise;
        logic sck_fall;
    } spi_edges_t;

endpackage

// File: rtl/spi_sync.sv
// Synchronizes the MCU's CS and SCK into clk and reports their edges.
// SCK edges are suppressed while CS is high; CS falls count only once CS has been seen high after reset.
module spi_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n_i,
    input  logic       sck_i,
    output spi_edges_t edges_o
);

    localparam int SETTLE = SYNC_STAGES + 1;
    localparam int SET_W  = $clog2(SETTLE + 1);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic                   cs_prev_q;
    logic                   sck_prev_q;
    logic [SET_W-1:0]       settle_q;
    logic                   armed_q;
    logic                   cs_s;
    logic                   sck_s;
    logic                   settled;

    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign settled = (settle_q == SET_W'(SETTLE));

    // The preset chain would fake a CS fall if the pin is already low at reset
    // release; arming waits for the chain to flush and CS to read high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            settle_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            settle_q   <= settled ? settle_q : settle_q + 1'b1;
            armed_q    <= armed_q | (settled & cs_s);
        end
    end

    always_comb begin
        edges_o          = '0;
        edges_o.cs_n     = cs_s;
        edges_o.cs_fall  = armed_q & cs_prev_q & ~cs_s;
        edges_o.cs_rise  = ~cs_prev_q & cs_s;
        edges_o.sck_rise = ~cs_s & ~sck_prev_q & sck_s;
        edges_o.sck_fall = ~cs_s & sck_prev_q & ~sck_s;
    end

endmodule

// File: rtl/spi_writer.sv
// SPI mode-0 responder transmit path: one-entry holding register feeding an
// MSB-first shift register clocked by oversampled SCK; fill byte on underrun.
module spi_writer
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter logic [DATA_W-1:0] FILL_BYTE   = DATA_W'(SPI_FILL_BYTE),
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    output logic              spi_out,
    output logic              spi_out_en,
    output logic              busy,
    output logic              word_done,
    output logic              underrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_edges_t        edges;
    spi_state_t        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              spi_out_q, spi_out_d;
    logic              busy_q, busy_d;
    logic              word_done_q, word_done_d;
    logic              underrun_q, underrun_d;
    logic              accept;
    logic              load;
    logic              last_bit;

    spi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .cs_n_i (spi_cs_n),
        .sck_i  (spi_sck),
        .edges_o(edges)
    );

    // Handshake: a word transfers on any cycle where tx_valid and tx_ready are both high.
    assign tx_ready = ~hold_full_q & ~rst;
    assign accept   = tx_valid & tx_ready;
    assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign load     = ((state_q == IDLE) & edges.cs_fall)
                    | ((state_q == ACTIVE) & edges.sck_fall & (bit_cnt_q == '0));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = 1'b0;
        underrun_d  = 1'b0;

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (edges.cs_fall) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (edges.cs_rise) begin
                    state_d   = IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else begin
                    if (edges.sck_rise) begin
                        bit_cnt_d   = last_bit ? '0 : bit_cnt_q + 1'b1;
                        word_done_d = last_bit;
                    end
                    if (edges.sck_fall && (bit_cnt_q != '0)) shift_d = shift_q << 1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A word accepted during an empty-hold load waits for the next load point.
        if (load) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shift_d    = FILL_BYTE;
                underrun_d = 1'b1;
            end
        end

        busy_d    = (state_d == ACTIVE) & ~edges.cs_n;
        spi_out_d = (state_d == ACTIVE) ? shift_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            spi_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            spi_out_q   <= spi_out_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_out    = spi_out_q;
    assign spi_out_en = busy_q;
    assign busy       = busy_q;
    assign word_done  = word_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_spi_writer.sv
// Bench for spi_writer: an MCU-side SPI master model samples spi_out on SCK rise
// and compares captured words and pulse counts with a word-level reference model.
module tb_spi_writer;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       spi_cs_n = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_out;
    logic       spi_out_en;
    logic       busy;
    logic       word_done;
    logic       underrun;

    int compared = 0;
    int mismatched = 0;
    int wd_cnt = 0;
    int ur_cnt = 0;
    int ur_at_start = 0;

    logic [7:0] hold_m[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       feed_en[0:7];
    logic [7:0] feed_val[0:7];

    spi_writer #(
        .DATA_W(8),
        .FILL_BYTE(8'hFF),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_out   (spi_out),
        .spi_out_en(spi_out_en),
        .busy      (busy),
        .word_done (word_done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_done === 1'b1) wd_cnt++;
        if (underrun === 1'b1) ur_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Word-level model: a load happens at CS fall and after every 8th SCK rise
    // that is followed by a falling edge inside the frame.
    task automatic model_frame(input int n_sck, output int exp_wd, output int exp_ur);
        int j;
        logic [7:0] w;
        exp_q.delete();
        exp_ur = 0;
        j = 0;
        while (j == 0 || 8 * j < n_sck) begin
            if (hold_m.size() > 0) w = hold_m.pop_front();
            else begin
                w = 8'hFF;
                exp_ur++;
            end
            if (8 * (j + 1) <= n_sck) exp_q.push_back(w);
            if (8 * j < n_sck && feed_en[j + 1]) hold_m.push_back(feed_val[j + 1]);
            j++;
        end
        exp_wd = n_sck / 8;
    endtask

    // MCU master: last SCK fall coincides with CS rise.
    task automatic frame(input int n_sck);
        logic [7:0] cur;
        int ur0;
        cur = 8'h00;
        ur0 = ur_cnt;
        rx_q.delete();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        ur_at_start = ur_cnt - ur0;
        check("busy_in_frame", {busy, spi_out_en}, 2'b11);
        for (int i = 0; i < n_sck; i++) begin
            cur = {cur[6:0], spi_out};
            spi_sck = 1'b1;
            if (i % 8 == 7) rx_q.push_back(cur);
            if (i % 8 == 0 && feed_en[i / 8 + 1]) push(feed_val[i / 8 + 1]);
            repeat (H) @(negedge clk);
            spi_sck = 1'b0;
            if (i == n_sck - 1) spi_cs_n = 1'b1;
            repeat (H) @(negedge clk);
        end
        repeat (H) @(negedge clk);
        check("busy_after_frame", {busy, spi_out_en, spi_out}, 3'b000);
    endtask

    task automatic run_frame(input string tag, input int n_sck);
        int exp_wd;
        int exp_ur;
        int wd0;
        int ur0;
        model_frame(n_sck, exp_wd, exp_ur);
        wd0 = wd_cnt;
        ur0 = ur_cnt;
        frame(n_sck);
        check({tag, "_nwords"}, rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
            check({tag, "_word"}, rx_q[k], exp_q[k]);
        check({tag, "_word_done"}, wd_cnt - wd0, exp_wd);
        check({tag, "_underrun"}, ur_cnt - ur0, exp_ur);
        foreach (feed_en[k]) feed_en[k] = 1'b0;
    endtask

    initial begin
        int wd0;
        int n;
        logic activity;
        logic [7:0] d;

        foreach (feed_en[k]) begin
            feed_en[k]  = 1'b0;
            feed_val[k] = 8'h00;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx_ready, spi_out, spi_out_en, busy, word_done, underrun}, 6'b0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", tx_ready, 1'b1);
        repeat (10) @(negedge clk);

        // Single word
        push(8'hA5);
        hold_m.push_back(8'hA5);
        check("t1_ready_low_when_full", tx_ready, 1'b0);
        run_frame("t1", 8);
        check("t1_ready_after_load", tx_ready, 1'b1);

        // Back-to-back words without CS toggle
        push(8'h3C);
        hold_m.push_back(8'h3C);
        feed_en[1]  = 1'b1;
        feed_val[1] = 8'hC3;
        run_frame("t2", 16);

        // Empty hold: fill byte, underrun at CS fall
        run_frame("t3", 8);
        check("t3_underrun_at_cs_fall", ur_at_start, 1);

        // Aborted frame loses its word
        push(8'h81);
        hold_m.push_back(8'h81);
        run_frame("t4_abort", 3);
        push(8'h7E);
        hold_m.push_back(8'h7E);
        run_frame("t4_next", 8);

        // Reset mid-word with a word in hold
        push(8'hAA);
        hold_m.push_back(8'hAA);
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            spi_sck = 1'b1;
            if (i == 0) push(8'h55);
            repeat (H) @(negedge clk);
            spi_sck = 1'b0;
            repeat (H) @(negedge clk);
        end
        check("t5_hold_full", tx_ready, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_outputs_in_reset", {tx_ready, spi_out, spi_out_en, busy, word_done, underrun}, 6'b0);
        rst = 1'b0;
        #1;
        check("t5_ready_after_reset", tx_ready, 1'b1);
        hold_m.delete();
        activity = 1'b0;
        wd0 = wd_cnt;
        for (int i = 0; i < 8; i++) begin
            spi_sck = 1'b1;
            for (int c = 0; c < 2 * H; c++) begin
                if (c == H) spi_sck = 1'b0;
                @(negedge clk);
                activity = activity | spi_out | busy | spi_out_en;
            end
        end
        check("t5_quiet_while_cs_low", activity, 1'b0);
        check("t5_no_word_done", wd_cnt - wd0, 0);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        run_frame("t5_after", 8);

        // Randomized frames
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 3))
                0: n = 8;
                1: n = 16;
                2: n = 24;
                default: n = $urandom_range(1, 23);
            endcase
            if (hold_m.size() == 0 && $urandom_range(0, 3) != 0) begin
                d = 8'($urandom_range(0, 255));
                push(d);
                hold_m.push_back(d);
            end
            for (int k = 1; k <= 3; k++) begin
                feed_en[k]  = 1'($urandom_range(0, 1));
                feed_val[k] = 8'($urandom_range(0, 255));
            end
            run_frame("rnd", n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
